// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared funct3 encodings and LSU state type
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT_RSP
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a load word and extends it
module lsu_load_align
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       offset,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[8*offset +: 8];
  assign half_sel = rdata[16*offset[1] +: 16];

  // Any funct3 that is not a byte or half encoding returns the full word.
  always_comb begin
    data_out = rdata;
    case (funct3)
      F3_B:    data_out = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_H:    data_out = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_BU:   data_out = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_HU:   data_out = {{(WIDTH-16){1'b0}}, half_sel};
      F3_W:    data_out = rdata;
      default: data_out = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with req/gnt/rvalid bus and MEM/WB register
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_out_exmem,
  input  logic [WIDTH-1:0] store_data_exmem,
  input  logic [4:0]       rd_exmem,
  input  logic [2:0]       funct3_exmem,
  input  logic             reg_write_exmem,
  input  logic             mem_read_exmem,
  input  logic             mem_write_exmem,
  input  logic             mem_to_reg_exmem,
  output logic             stall_mem,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] wb_data_memwb,
  output logic [4:0]       rd_memwb,
  output logic             reg_write_memwb,
  output logic             misaligned_memwb
);

  lsu_state_t       state_q, state_d;
  logic [1:0]       off;
  logic             is_mem, is_half, is_word, misaligned;
  logic             wb_en, wb_sel_mem, mis_d;
  logic [WIDTH-1:0] load_ext;

  assign off        = alu_out_exmem[1:0];
  assign is_mem     = mem_read_exmem | mem_write_exmem;
  assign is_half    = (funct3_exmem[1:0] == 2'b01);
  assign is_word    = funct3_exmem[1];
  assign misaligned = is_mem & ((is_half & off[0]) | (is_word & (|off)));

  // A set mem_write wins, so read+write together behaves as a store.
  assign dmem_we   = mem_write_exmem;
  assign dmem_addr = {alu_out_exmem[WIDTH-1:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = store_data_exmem;
    if (!funct3_exmem[1]) begin
      if (funct3_exmem[0]) begin
        dmem_be    = 4'b0011 << off;
        dmem_wdata = {2{store_data_exmem[15:0]}};
      end else begin
        dmem_be    = 4'b0001 << off;
        dmem_wdata = {4{store_data_exmem[7:0]}};
      end
    end
  end

  lsu_load_align #(.WIDTH(WIDTH)) u_load_align (
    .rdata    (dmem_rdata),
    .offset   (off),
    .funct3   (funct3_exmem),
    .data_out (load_ext)
  );

  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    stall_mem  = 1'b0;
    wb_en      = 1'b0;
    wb_sel_mem = 1'b0;
    mis_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!is_mem) begin
          wb_en = 1'b1;
        end else if (misaligned) begin
          mis_d = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (!dmem_gnt) begin
            stall_mem = 1'b1;
          end else if (!mem_write_exmem) begin
            state_d   = WAIT_RSP;
            stall_mem = 1'b1;
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid) begin
          wb_en      = 1'b1;
          wb_sel_mem = mem_to_reg_exmem;
          state_d    = IDLE;
        end else begin
          stall_mem = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Upstream must not see a stall or a request while held in reset.
    if (rst) begin
      dmem_req  = 1'b0;
      stall_mem = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      wb_data_memwb    <= '0;
      rd_memwb         <= '0;
      reg_write_memwb  <= 1'b0;
      misaligned_memwb <= 1'b0;
    end else begin
      state_q          <= state_d;
      misaligned_memwb <= mis_d;
      if (wb_en) begin
        wb_data_memwb   <= wb_sel_mem ? load_ext : alu_out_exmem;
        rd_memwb        <= rd_exmem;
        reg_write_memwb <= reg_write_exmem;
      end else begin
        wb_data_memwb   <= '0;
        rd_memwb        <= '0;
        reg_write_memwb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed and randomized checks of mem_stage_lsu against a reference model
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_exmem, store_data_exmem;
  logic [4:0]  rd_exmem;
  logic [2:0]  funct3_exmem;
  logic        reg_write_exmem, mem_read_exmem, mem_write_exmem, mem_to_reg_exmem;
  logic        stall_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data_memwb;
  logic [4:0]  rd_memwb;
  logic        reg_write_memwb, misaligned_memwb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk              (clk),
    .rst              (rst),
    .alu_out_exmem    (alu_out_exmem),
    .store_data_exmem (store_data_exmem),
    .rd_exmem         (rd_exmem),
    .funct3_exmem     (funct3_exmem),
    .reg_write_exmem  (reg_write_exmem),
    .mem_read_exmem   (mem_read_exmem),
    .mem_write_exmem  (mem_write_exmem),
    .mem_to_reg_exmem (mem_to_reg_exmem),
    .stall_mem        (stall_mem),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_be          (dmem_be),
    .dmem_wdata       (dmem_wdata),
    .dmem_gnt         (dmem_gnt),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .wb_data_memwb    (wb_data_memwb),
    .rd_memwb         (rd_memwb),
    .reg_write_memwb  (reg_write_memwb),
    .misaligned_memwb (misaligned_memwb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [2:0] f3);
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] f3);
    int n;
    n = size_of(f3);
    if (n == 4) return 4'hF;
    return 4'((2 ** n - 1) * (2 ** (a % 4)));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input logic [2:0] f3);
    int n;
    n = size_of(f3);
    if (n == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] a,
                                           input logic [2:0] f3);
    int n;
    logic [31:0] v, lim;
    bit sgn;
    n = size_of(f3);
    if (n == 4) return rdata;
    sgn = (f3 < 3'd4);
    lim = 32'd1 << (8 * n);
    v   = (rdata >> (8 * (a % 4))) % lim;
    if (sgn && v >= lim / 2) v = v - lim;
    return v;
  endfunction

  task automatic set_ctrl(input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic [2:0] f3, input logic rw, input logic mr, input logic mw,
                          input logic m2r);
    alu_out_exmem    = a;
    store_data_exmem = rs2;
    rd_exmem         = rd;
    funct3_exmem     = f3;
    reg_write_exmem  = rw;
    mem_read_exmem   = mr;
    mem_write_exmem  = mw;
    mem_to_reg_exmem = m2r;
  endtask

  // Runs one EX/MEM op to completion; gw = cycles gnt is held low, rw_wait = cycles before rvalid.
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic rw,
                       input logic mr, input logic mw, input logic m2r,
                       input int gw, input int rw_wait, input logic [31:0] rdata);
    bit is_mem, is_st;
    int stalls;
    int accepted;
    is_mem   = mr || mw;
    is_st    = mw;
    stalls   = 0;
    accepted = 0;
    set_ctrl(a, rs2, rd, f3, rw, mr, mw, m2r);
    dmem_rdata = rdata;
    if (!is_mem) begin
      dmem_gnt    = 1'($urandom_range(0, 1));
      dmem_rvalid = 1'($urandom_range(0, 1));
      #1;
      check({nm, "_req"}, 32'(dmem_req), 32'd0);
      check({nm, "_stall"}, 32'(stall_mem), 32'd0);
      @(posedge clk); #1;
      check({nm, "_wb"}, wb_data_memwb, a);
      check({nm, "_rd"}, 32'(rd_memwb), 32'(rd));
      check({nm, "_rw"}, 32'(reg_write_memwb), 32'(rw));
    end else if (ref_misaligned(a, f3)) begin
      dmem_gnt    = 1'($urandom_range(0, 1));
      dmem_rvalid = 1'b0;
      #1;
      check({nm, "_mis_req"}, 32'(dmem_req), 32'd0);
      check({nm, "_mis_stall"}, 32'(stall_mem), 32'd0);
      @(posedge clk); #1;
      check({nm, "_mis_flag"}, 32'(misaligned_memwb), 32'd1);
      check({nm, "_mis_rw"}, 32'(reg_write_memwb), 32'd0);
      set_ctrl(32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check({nm, "_mis_pulse"}, 32'(misaligned_memwb), 32'd0);
    end else begin
      for (int i = 0; i < gw; i++) begin
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'($urandom_range(0, 1));
        #1;
        check({nm, "_wreq"}, 32'(dmem_req), 32'd1);
        stalls += int'(stall_mem);
        @(posedge clk); #1;
        check({nm, "_wbub"}, 32'(reg_write_memwb), 32'd0);
      end
      dmem_gnt    = 1'b1;
      dmem_rvalid = 1'($urandom_range(0, 1));
      #1;
      check({nm, "_req"}, 32'(dmem_req), 32'd1);
      check({nm, "_we"}, 32'(dmem_we), 32'(is_st));
      check({nm, "_addr"}, dmem_addr, a - (a % 4));
      if (is_st) begin
        check({nm, "_be"}, 32'(dmem_be), 32'(ref_be(a, f3)));
        check({nm, "_wdata"}, dmem_wdata, ref_wdata(rs2, f3));
      end
      stalls   += int'(stall_mem);
      accepted += int'(dmem_req && dmem_gnt);
      @(posedge clk); #1;
      check({nm, "_gbub"}, 32'(reg_write_memwb), 32'd0);
      dmem_gnt = 1'b0;
      if (!is_st) begin
        for (int i = 0; i < rw_wait; i++) begin
          dmem_rvalid = 1'b0;
          #1;
          check({nm, "_rreq"}, 32'(dmem_req), 32'd0);
          stalls += int'(stall_mem);
          @(posedge clk); #1;
          check({nm, "_rbub"}, 32'(reg_write_memwb), 32'd0);
        end
        dmem_rvalid = 1'b1;
        #1;
        check({nm, "_vreq"}, 32'(dmem_req), 32'd0);
        stalls += int'(stall_mem);
        @(posedge clk); #1;
        check({nm, "_ldata"}, wb_data_memwb, m2r ? ref_load(rdata, a, f3) : a);
        check({nm, "_lrd"}, 32'(rd_memwb), 32'(rd));
        check({nm, "_lrw"}, 32'(reg_write_memwb), 32'(rw));
        dmem_rvalid = 1'b0;
      end
      check({nm, "_stalls"}, 32'(stalls), 32'(is_st ? gw : gw + 1 + rw_wait));
      check({nm, "_accepted"}, 32'(accepted), 32'd1);
    end
  endtask

  initial begin
    int kind;
    logic [31:0] a, rs2, rdata;
    logic [2:0]  f3;
    logic        mr, mw;

    rst = 1'b1;
    set_ctrl(32'h104, 32'h0, 5'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_mem), 32'd0);
    check("rst_wb", wb_data_memwb, 32'd0);
    check("rst_rd", 32'(rd_memwb), 32'd0);
    check("rst_rw", 32'(reg_write_memwb), 32'd0);
    check("rst_mis", 32'(misaligned_memwb), 32'd0);
    set_ctrl(32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("add", 32'h0000_1234, 32'h0, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    do_op("sb",  32'h0000_0103, 32'hAB, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0);
    do_op("lb",  32'h0000_0102, 32'h0, 5'd7, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 2, 0, 32'h0080_0000);
    do_op("lhu", 32'h0000_0202, 32'h0, 5'd8, 3'b101, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 32'h8001_0000);
    do_op("lh",  32'h0000_0202, 32'h0, 5'd9, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2, 32'h8001_0000);
    do_op("lw_mis", 32'h0000_0301, 32'h0, 5'd4, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0);
    do_op("sh",  32'h0000_0012, 32'hBEEF_CAFE, 5'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 32'h0);
    do_op("rdwr", 32'h0000_0020, 32'h1357_9BDF, 5'd2, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      rs2   = $urandom;
      rdata = $urandom;
      f3    = 3'($urandom_range(0, 5));
      mr    = (kind == 1) || (kind == 3);
      mw    = (kind == 2) || (kind == 3);
      do_op("rnd", a, rs2, 5'($urandom), f3, 1'($urandom_range(0, 1)), mr, mw,
            1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), rdata);
    end

    // Reset while a load is waiting for its response.
    set_ctrl(32'h400, 32'h0, 5'd6, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #1;
    check("wait_stall", 32'(stall_mem), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall", 32'(stall_mem), 32'd0);
    check("mid_rst_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    #1;
    check("post_rst_req", 32'(dmem_req), 32'd1);
    check("post_rst_stall", 32'(stall_mem), 32'd1);
    @(posedge clk); #1;
    check("stale_rv_rw", 32'(reg_write_memwb), 32'd0);
    check("stale_rv_wb", wb_data_memwb, 32'd0);
    set_ctrl(32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_rvalid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
